// File: rtl/if_stage_q.sv
// if_stage_q: instruction-fetch stage with a small fetch queue.
// Issues one read per cycle to a latency-1 instruction memory. It buffers the
// returned words so decode can stall without losing fetches. Redirects flush
// the queue and toggle an epoch so that stale responses are discarded.
module if_stage_q #(
  parameter int unsigned          XLEN     = 32,
  parameter logic [XLEN-1:0]      RESET_PC = '0,
  parameter int unsigned          IMEM_AW  = 10,
  parameter int unsigned          FQ_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                jump,
  input  logic [XLEN-1:0]     jump_target,
  input  logic                pc_src,
  input  logic [XLEN-1:0]     branch_target,
  output logic                imem_req,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [XLEN-1:0]     imem_rdata,
  output logic                if_valid,
  input  logic                id_ready,
  output logic [XLEN-1:0]     if_instr,
  output logic [XLEN-1:0]     if_pc,
  output logic [XLEN-1:0]     if_pc_plus4
);

  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FQ_DEPTH);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc_q;
  logic            req_epoch_q;
  logic            epoch_q;
  logic            inflight_q;
  logic [CW-1:0]   count_q;
  logic [PW-1:0]   head_q;
  logic [PW-1:0]   tail_q;
  logic [XLEN-1:0] q_instr [FQ_DEPTH];
  logic [XLEN-1:0] q_pc    [FQ_DEPTH];

  logic            redir;
  logic [XLEN-1:0] target;
  logic            has_data;
  logic            pop;
  logic            push;
  logic [CW:0]     occupancy;

  // Redirect selection, handshake, occupancy and the combinational output view
  always_comb begin
    redir     = jump | pc_src;
    target    = jump ? jump_target : branch_target;
    target    = {target[XLEN-1:2], 2'b00};
    has_data  = (count_q != '0);
    if_valid  = has_data & ~redir;
    pop       = if_valid & id_ready;
    push      = inflight_q & (req_epoch_q == epoch_q) & ~redir;
    // A pop in this cycle frees a slot that the new request may claim.
    occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
    imem_req  = rst_n & ~redir & (occupancy < DEPTH_C);
    imem_addr = pc_q[IMEM_AW+1:2];
    if_instr    = '0;
    if_pc       = '0;
    if_pc_plus4 = '0;
    if (has_data) begin
      if_instr    = q_instr[head_q];
      if_pc       = q_pc[head_q];
      if_pc_plus4 = q_pc[head_q] + XLEN'(4);
    end
  end

  // PC, request tracking, epoch and queue pointer/count bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
      inflight_q  <= 1'b0;
      count_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
    end else if (redir) begin
      pc_q       <= target;
      epoch_q    <= ~epoch_q;
      inflight_q <= 1'b0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      if (imem_req) begin
        pc_q        <= pc_q + XLEN'(4);
        req_pc_q    <= pc_q;
        req_epoch_q <= epoch_q;
      end
      inflight_q <= imem_req;
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Queue storage: a valid, current-epoch response is written at the tail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FQ_DEPTH); i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (push) begin
      q_instr[tail_q] <= imem_rdata;
      q_pc[tail_q]    <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_if_stage_q.sv
// tb_if_stage_q: randomized and directed bench for if_stage_q.
// A queue-based reference model tracks the fetch stream. The model holds the
// fetched-but-undelivered PCs, one pending request and the next fetch PC.
module tb_if_stage_q;

  localparam int unsigned   XLEN     = 32;
  localparam int unsigned   AW       = 10;
  localparam int unsigned   DEPTH    = 2;
  localparam logic [31:0]   RESET_PC = 32'h0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              jump;
  logic [XLEN-1:0]   jump_target;
  logic              pc_src;
  logic [XLEN-1:0]   branch_target;
  logic              imem_req;
  logic [AW-1:0]     imem_addr;
  logic [XLEN-1:0]   imem_rdata;
  logic              if_valid;
  logic              id_ready;
  logic [XLEN-1:0]   if_instr;
  logic [XLEN-1:0]   if_pc;
  logic [XLEN-1:0]   if_pc_plus4;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mq[$];
  bit          pend;
  logic [31:0] pend_pc;
  logic [31:0] mpc;

  if_stage_q #(
    .XLEN(XLEN), .RESET_PC(RESET_PC), .IMEM_AW(AW), .FQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .jump(jump), .jump_target(jump_target),
    .pc_src(pc_src), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .id_ready(id_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [AW-1:0] a);
    return 32'h00000013 ^ ({22'd0, a} * 32'h9E3779B1);
  endfunction

  // latency-1 memory; garbage when not requested
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= instrOf(imem_addr);
    else          imem_rdata <= $urandom;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
    end
  endtask

  // one cycle: drive at negedge, check shortly after, advance the model
  task automatic applyStimulus(input logic rst, input logic j, input logic [31:0] jt,
                               input logic ps, input logic [31:0] bt, input logic rdy);
    bit          redir;
    bit          exp_valid;
    bit          exp_pop;
    bit          exp_req;
    logic [31:0] hp;
    logic [31:0] tgt;
    @(negedge clk);
    rst_n = rst; jump = j; jump_target = jt; pc_src = ps; branch_target = bt; id_ready = rdy;
    #1;
    redir     = (j | ps);
    exp_valid = 1'b0;
    exp_pop   = 1'b0;
    exp_req   = 1'b0;
    if (rst) begin
      exp_valid = (mq.size() != 0) && !redir;
      exp_pop   = exp_valid && rdy;
      exp_req   = !redir && (mq.size() + int'(pend) - int'(exp_pop) < int'(DEPTH));
    end
    checkOutput("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
    checkOutput("if_valid", {31'd0, if_valid}, {31'd0, exp_valid});
    if (rst) checkOutput("imem_addr", {22'd0, imem_addr}, {22'd0, mpc[11:2]});
    if (exp_valid) begin
      hp = mq[0];
      checkOutput("if_pc", if_pc, hp);
      checkOutput("if_instr", if_instr, instrOf(hp[11:2]));
      checkOutput("if_pc_plus4", if_pc_plus4, hp + 32'd4);
    end
    if (!rst) begin
      checkOutput("rst_if_pc", if_pc, 32'd0);
      checkOutput("rst_if_instr", if_instr, 32'd0);
      checkOutput("rst_if_pc_plus4", if_pc_plus4, 32'd0);
    end
    tgt = j ? jt : bt;
    if (!rst) begin
      mq.delete(); pend = 0; mpc = RESET_PC;
    end else if (redir) begin
      mq.delete(); pend = 0; mpc = tgt & ~32'h3;
    end else begin
      if (exp_pop) void'(mq.pop_front());
      if (pend) mq.push_back(pend_pc);
      pend = exp_req;
      if (exp_req) begin
        pend_pc = mpc;
        mpc     = mpc + 32'd4;
      end
    end
  endtask

  task automatic runCycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, rdy);
  endtask

  initial begin
    rst_n = 1'b0; jump = 1'b0; pc_src = 1'b0; id_ready = 1'b0;
    jump_target = '0; branch_target = '0;
    mq.delete(); pend = 0; pend_pc = '0; mpc = RESET_PC;

    // reset held, then release with ID ready
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    runCycles(4, 1'b1);
    // stall with head at 0x8, then drain
    runCycles(5, 1'b0);
    runCycles(4, 1'b1);
    // taken branch
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h40, 1'b1);
    runCycles(4, 1'b1);
    // jump and branch together: jump wins
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1);
    runCycles(4, 1'b1);
    // misaligned target near the top of the address space
    applyStimulus(1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 32'd0, 1'b1);
    runCycles(5, 1'b1);
    // back-to-back redirects
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 32'h500, 1'b1);
    runCycles(4, 1'b1);
    // fill the queue under stall, then reset mid-operation
    runCycles(5, 1'b0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    runCycles(5, 1'b1);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic        r, j, ps, rdy;
      logic [31:0] jt, bt;
      r   = ($urandom_range(0, 199) != 0);
      j   = ($urandom_range(0, 15) == 0);
      ps  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      jt  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      bt  = $urandom;
      applyStimulus(r, j, jt, ps, bt, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
